mul_cdb_unit: RTL and testbench

- Pipelined integer multiply execution unit.
- Consumes single-issue ops from the multiply reservation station and drives the MUL result-broadcast channel (we_MUL / tag_MUL / val_MUL) that all reservation stations snoop for operand wakeup.
- Also supplies dst_MUL for register-file / commit writeback.
- Fixed latency, one new op per cycle, in-order completion.

---
 rtl/mul_cdb_unit_if.sv | 25 ++
 rtl/mul_cdb_unit.sv | 82 ++++++++
 tb/tb_mul_cdb_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_cdb_unit_if.sv
// Issue and result-broadcast bundle of the multiply unit.
// The reservation-station side uses "master"; the unit itself uses "slave".
interface mul_cdb_unit_if;
  logic        issue_we;
  logic [4:0]  issue_op;
  logic [4:0]  issue_dst;
  logic [4:0]  issue_tag;
  logic [31:0] issue_val1;
  logic [31:0] issue_val2;
  logic        we_MUL;
  logic [4:0]  tag_MUL;
  logic [4:0]  dst_MUL;
  logic [31:0] val_MUL;
  logic        busy;

  modport master (
    output issue_we, issue_op, issue_dst, issue_tag, issue_val1, issue_val2,
    input  we_MUL, tag_MUL, dst_MUL, val_MUL, busy
  );

  modport slave (
    input  issue_we, issue_op, issue_dst, issue_tag, issue_val1, issue_val2,
    output we_MUL, tag_MUL, dst_MUL, val_MUL, busy
  );
endinterface

// File: rtl/mul_cdb_unit.sv
// Fixed-latency pipelined 32x32 multiply feeding the MUL broadcast channel.
// LATENCY (1..8) stages; one op per cycle, in-order completion.
module mul_cdb_unit #(
  parameter int LATENCY = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  mul_cdb_unit_if.slave  bus
);

  localparam int LAST = LATENCY - 1;

  logic              accept;
  logic [31:0]       mul_result;
  logic signed [63:0] opnd_a;
  logic signed [63:0] opnd_b;
  logic signed [63:0] product;
  logic              unused_op;

  logic [LATENCY-1:0] vld;
  logic [4:0]         tag_q [LATENCY];
  logic [4:0]         dst_q [LATENCY];
  logic [31:0]        res_q [LATENCY];

  assign accept    = bus.issue_we & ~stall & ~flush & (bus.issue_dst != 5'd0);
  assign unused_op = ^bus.issue_op[4:2];

  // Product is formed at capture; later stages only carry it forward.
  always_comb begin
    opnd_a = 64'sd0;
    opnd_b = 64'sd0;
    if (bus.issue_op[0]) begin
      opnd_a = {32'd0, bus.issue_val1};
      opnd_b = {32'd0, bus.issue_val2};
    end else begin
      opnd_a = {{32{bus.issue_val1[31]}}, bus.issue_val1};
      opnd_b = {{32{bus.issue_val2[31]}}, bus.issue_val2};
    end
    product    = opnd_a * opnd_b;
    mul_result = bus.issue_op[1] ? product[63:32] : product[31:0];
  end

  // Payload registers only load behind a valid op, so the last stage
  // keeps presenting the most recent result while no op is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
        dst_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else if (!stall) begin
      vld[0] <= accept;
      if (accept) begin
        tag_q[0] <= bus.issue_tag;
        dst_q[0] <= bus.issue_dst;
        res_q[0] <= mul_result;
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          tag_q[k] <= tag_q[k-1];
          dst_q[k] <= dst_q[k-1];
          res_q[k] <= res_q[k-1];
        end
      end
    end
  end

  // A stalled last stage holds, so its result broadcasts once stall drops.
  assign bus.we_MUL  = vld[LAST] & ~stall & ~flush & ~reset;
  assign bus.tag_MUL = tag_q[LAST];
  assign bus.dst_MUL = dst_q[LAST];
  assign bus.val_MUL = res_q[LAST];
  assign bus.busy    = |vld;

endmodule

// File: tb/tb_mul_cdb_unit.sv
// Self-checking bench for mul_cdb_unit: directed scenarios plus a randomized
// run against a queue-based behavioural model.
module tb_mul_cdb_unit;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset, stall, flush;
  int   total = 0;
  int   bad   = 0;

  mul_cdb_unit_if bus ();

  mul_cdb_unit #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  dst;
    logic [31:0] val;
    int          steps;
  } ent_t;

  function automatic logic [31:0] ref_mul(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint pa, pb, p;
    if (op[0]) begin
      pa = longint'({32'd0, a});
      pb = longint'({32'd0, b});
    end else begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end
    p = pa * pb;
    return op[1] ? p[63:32] : p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_we = 1'b0;
  endtask

  task automatic set_issue(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                           logic [4:0] tag, logic [4:0] dst);
    bus.issue_we   = 1'b1;
    bus.issue_op   = op;
    bus.issue_val1 = a;
    bus.issue_val2 = b;
    bus.issue_tag  = tag;
    bus.issue_dst  = dst;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.we_MUL, bus.tag_MUL, bus.dst_MUL, bus.val_MUL, bus.busy} !== 44'd0) begin
      bad++;
      $display("FAIL reset_state got we=%b tag=%0d dst=%0d val=%h busy=%b exp all 0",
               bus.we_MUL, bus.tag_MUL, bus.dst_MUL, bus.val_MUL, bus.busy);
    end
  endtask

  task automatic test_basic();
    logic exp_we;
    set_issue(5'b00000, 32'd7, 32'hFFFFFFFD, 5'd9, 5'd4);
    tick();
    idle();
    for (int k = 1; k <= 5; k++) begin
      #1;
      exp_we = (k == LAT);
      total++;
      if (bus.we_MUL !== exp_we) begin
        bad++;
        $display("FAIL basic_we cycle=%0d got=%b exp=%b", k, bus.we_MUL, exp_we);
      end
      if (k == LAT) begin
        total++;
        if ({bus.tag_MUL, bus.dst_MUL, bus.val_MUL} !== {5'd9, 5'd4, 32'hFFFFFFEB}) begin
          bad++;
          $display("FAIL basic_result got tag=%0d dst=%0d val=%h exp tag=9 dst=4 val=ffffffeb",
                   bus.tag_MUL, bus.dst_MUL, bus.val_MUL);
        end
      end
      tick();
    end
  endtask

  task automatic test_arith();
    logic [4:0]  ops [3];
    logic [31:0] va  [3];
    logic [31:0] vb  [3];
    logic [31:0] ex  [3];
    int          seen_k;
    logic [31:0] seen_val;
    ops = '{5'b00011, 5'b00010, 5'b11100};
    va  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    vb  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    ex  = '{32'hFFFFFFFE, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 3; i++) begin
      set_issue(ops[i], va[i], vb[i], 5'(20 + i), 5'd7);
      tick();
      idle();
      seen_k   = -1;
      seen_val = '0;
      for (int k = 1; k <= 8; k++) begin
        #1;
        if (bus.we_MUL === 1'b1) begin
          seen_k   = k;
          seen_val = bus.val_MUL;
          break;
        end
        tick();
      end
      tick();
      total++;
      if (seen_k != LAT || seen_val !== ex[i]) begin
        bad++;
        $display("FAIL arith_%0d got cycle=%0d val=%h exp cycle=%0d val=%h",
                 i, seen_k, seen_val, LAT, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_val [3];
    logic        exp_we;
    exp_val = '{32'd6, 32'd20, 32'd42};
    for (int i = 0; i < 3; i++) begin
      set_issue(5'b00000, 32'(2 * i + 2), 32'(2 * i + 3), 5'(i + 1), 5'(i + 10));
      tick();
    end
    idle();
    for (int j = 0; j < 5; j++) begin
      #1;
      exp_we = (j < 3);
      total++;
      if (bus.we_MUL !== exp_we) begin
        bad++;
        $display("FAIL b2b_we cycle=%0d got=%b exp=%b", j + LAT, bus.we_MUL, exp_we);
      end
      if (j < 3) begin
        total++;
        if ({bus.tag_MUL, bus.dst_MUL, bus.val_MUL} !== {5'(j + 1), 5'(j + 10), exp_val[j]}) begin
          bad++;
          $display("FAIL b2b_result %0d got tag=%0d dst=%0d val=%h exp tag=%0d dst=%0d val=%h",
                   j, bus.tag_MUL, bus.dst_MUL, bus.val_MUL, j + 1, j + 10, exp_val[j]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic       exp_we [7];
    logic [4:0] exp_tag [7];
    logic       stl    [7];
    // cycles after tag 5 is accepted: 2..8 (tag 5 reaches last stage at 3)
    stl     = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_we  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_tag = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd0};
    set_issue(5'b00001, 32'd100, 32'd3, 5'd5, 5'd1);
    tick();
    set_issue(5'b00001, 32'd11, 32'd11, 5'd6, 5'd2);
    tick();
    idle();
    for (int j = 0; j < 7; j++) begin
      stall = stl[j];
      #1;
      total++;
      if (bus.we_MUL !== exp_we[j]) begin
        bad++;
        $display("FAIL stall_we cycle=%0d got=%b exp=%b", j + 2, bus.we_MUL, exp_we[j]);
      end
      if (exp_we[j]) begin
        total++;
        if (bus.tag_MUL !== exp_tag[j] ||
            bus.val_MUL !== ((exp_tag[j] == 5'd5) ? 32'd300 : 32'd121)) begin
          bad++;
          $display("FAIL stall_result cycle=%0d got tag=%0d val=%h exp tag=%0d",
                   j + 2, bus.tag_MUL, bus.val_MUL, exp_tag[j]);
        end
      end
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic test_dst_zero();
    set_issue(5'b00000, 32'd3, 32'd3, 5'd7, 5'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (bus.we_MUL !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL dst_zero cycle=%0d got we=%b busy=%b exp we=0 busy=0",
                 k, bus.we_MUL, bus.busy);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    set_issue(5'b00000, 32'd5, 32'd5, 5'd1, 5'd1);
    tick();
    set_issue(5'b00000, 32'd6, 32'd6, 5'd2, 5'd2);
    tick();
    set_issue(5'b00000, 32'd7, 32'd7, 5'd3, 5'd3);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.we_MUL !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear got busy=%b we=%b exp busy=0 we=0", bus.busy, bus.we_MUL);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (bus.we_MUL !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL flush_quiet cycle=%0d got we=%b busy=%b exp 0", k, bus.we_MUL, bus.busy);
      end
    end
    // flush while the op sits in the last stage
    set_issue(5'b00000, 32'd9, 32'd9, 5'd4, 5'd4);
    tick();
    idle();
    for (int k = 1; k < LAT; k++) tick();
    flush = 1'b1;
    #1;
    total++;
    if (bus.we_MUL !== 1'b0) begin
      bad++;
      $display("FAIL flush_last_stage got we=%b exp=0", bus.we_MUL);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (bus.we_MUL !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_after got we=%b busy=%b exp 0", bus.we_MUL, bus.busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic exp_we;
    set_issue(5'b00000, 32'd8, 32'd8, 5'd10, 5'd5);
    tick();
    set_issue(5'b00000, 32'd9, 32'd9, 5'd11, 5'd6);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.we_MUL, bus.tag_MUL, bus.dst_MUL, bus.val_MUL, bus.busy} !== 44'd0) begin
      bad++;
      $display("FAIL reset_mid_state got we=%b tag=%0d dst=%0d val=%h busy=%b exp all 0",
               bus.we_MUL, bus.tag_MUL, bus.dst_MUL, bus.val_MUL, bus.busy);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bus.we_MUL !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_quiet cycle=%0d got we=%b exp=0", k, bus.we_MUL);
      end
    end
    set_issue(5'b00000, 32'd2, 32'd9, 5'd12, 5'd3);
    tick();
    idle();
    for (int k = 1; k <= LAT + 1; k++) begin
      #1;
      exp_we = (k == LAT);
      total++;
      if (bus.we_MUL !== exp_we ||
          (exp_we && {bus.tag_MUL, bus.dst_MUL, bus.val_MUL} !== {5'd12, 5'd3, 32'd18})) begin
        bad++;
        $display("FAIL reset_mid_after cycle=%0d got we=%b tag=%0d dst=%0d val=%h exp we=%b tag=12 dst=3 val=12",
                 k, bus.we_MUL, bus.tag_MUL, bus.dst_MUL, bus.val_MUL, exp_we);
      end
      tick();
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic        exp_we;
    logic        acc;
    logic [31:0] corner [4];
    corner = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001};
    for (int i = 0; i < 400 + LAT + 3; i++) begin
      if (i < 400) begin
        stall          = ($urandom_range(0, 5) == 0);
        flush          = ($urandom_range(0, 29) == 0);
        bus.issue_we   = ($urandom_range(0, 3) != 0);
        bus.issue_op   = 5'($urandom);
        bus.issue_tag  = 5'($urandom);
        bus.issue_dst  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.issue_val1 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        bus.issue_val2 = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      end else begin
        stall = 1'b0;
        flush = 1'b0;
        idle();
      end
      #1;
      exp_we = (q.size() > 0) && (q[0].steps == LAT - 1) && !stall && !flush;
      total++;
      if (bus.we_MUL !== exp_we || bus.busy !== (q.size() != 0)) begin
        bad++;
        $display("FAIL random_ctrl iter=%0d got we=%b busy=%b exp we=%b busy=%b",
                 i, bus.we_MUL, bus.busy, exp_we, q.size() != 0);
      end
      if (exp_we) begin
        total++;
        if ({bus.tag_MUL, bus.dst_MUL, bus.val_MUL} !== {q[0].tag, q[0].dst, q[0].val}) begin
          bad++;
          $display("FAIL random_result iter=%0d got tag=%0d dst=%0d val=%h exp tag=%0d dst=%0d val=%h",
                   i, bus.tag_MUL, bus.dst_MUL, bus.val_MUL, q[0].tag, q[0].dst, q[0].val);
        end
      end
      acc = bus.issue_we && !stall && !flush && (bus.issue_dst != 5'd0);
      if (flush) begin
        q.delete();
      end else if (!stall) begin
        if (exp_we) void'(q.pop_front());
        foreach (q[j]) q[j].steps++;
        if (acc) begin
          e.tag   = bus.issue_tag;
          e.dst   = bus.issue_dst;
          e.val   = ref_mul(bus.issue_op, bus.issue_val1, bus.issue_val2);
          e.steps = 0;
          q.push_back(e);
        end
      end
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    bus.issue_we   = 1'b0;
    bus.issue_op   = '0;
    bus.issue_dst  = '0;
    bus.issue_tag  = '0;
    bus.issue_val1 = '0;
    bus.issue_val2 = '0;
    test_reset();
    test_basic();
    test_arith();
    test_back_to_back();
    test_stall();
    test_dst_zero();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
